// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter frame width, queue FSM states and
// byte-to-frame zero extension.
package uart_pkg;

    localparam int FRAME_W = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } txq_state_e;

    // Clears every bit at or above data_w so narrow bytes reach uart_tx zero-extended.
    function automatic logic [FRAME_W-1:0] frame_ext(input logic [FRAME_W-1:0] raw,
                                                      input int data_w);
        logic [FRAME_W-1:0] mask;
        mask = '0;
        for (int i = 0; i < FRAME_W; i++) mask[i] = (i < data_w);
        return raw & mask;
    endfunction

endpackage

// File: rtl/uart_tx_queue_if.sv
// Host write port plus transmitter handshake of uart_tx_queue.
// UART_TXQ_OVF_EN adds the sticky overflow flag.
interface uart_tx_queue_if #(
    parameter int DATA_W  = 8,
    parameter int FRAME_W = uart_pkg::FRAME_W
);
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              full;
    logic              empty;
    logic [FRAME_W-1:0] tx_data;
    logic              tx_start;
    logic              tx_busy;
`ifdef UART_TXQ_OVF_EN
    logic              overflow;
`endif

    modport master (
        output wr_en, wr_data, tx_busy,
        input  full, empty, tx_data, tx_start
`ifdef UART_TXQ_OVF_EN
        , input overflow
`endif
    );

    modport slave (
        input  wr_en, wr_data, tx_busy,
        output full, empty, tx_data, tx_start
`ifdef UART_TXQ_OVF_EN
        , output overflow
`endif
    );
endinterface

// File: rtl/uart_txq_fifo.sv
// Synchronous FIFO with registered full/empty; head entry is presented
// combinationally on rd_data.
module uart_txq_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count, count_nxt;
    logic              push_ok, pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        case ({push_ok, pop_ok})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue feeding uart_tx through its start/busy handshake.
// UART_TXQ_OVF_EN enables the sticky overflow output.
module uart_tx_queue #(
    parameter int DEPTH   = 8,
    parameter int DATA_W  = 8,
    parameter int FRAME_W = 10
) (
    input logic             clk,
    input logic             reset,
    uart_tx_queue_if.slave  bus
);
    import uart_pkg::*;

    localparam logic [1:0] S_IDLE  = 2'(IDLE);
    localparam logic [1:0] S_START = 2'(START);
    localparam logic [1:0] S_WAIT  = 2'(WAIT);

    logic [1:0]        state;
    logic [DATA_W-1:0] head;
    logic              pop;

    // Pop decision only feeds the FIFO and registers, never an output directly.
    assign pop          = (state == S_IDLE) && !bus.empty && !bus.tx_busy;
    assign bus.tx_start = (state == S_START);

    uart_txq_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (bus.wr_en),
        .wr_data (bus.wr_data),
        .pop     (pop),
        .rd_data (head),
        .full    (bus.full),
        .empty   (bus.empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            bus.tx_data <= '0;
        end else begin
            case (state)
                S_IDLE: if (pop) begin
                    bus.tx_data <= frame_ext(FRAME_W'(head), DATA_W);
                    state       <= S_START;
                end
                S_START: if (bus.tx_busy)  state <= S_WAIT;
                S_WAIT:  if (!bus.tx_busy) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef UART_TXQ_OVF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                      bus.overflow <= 1'b0;
        else if (bus.wr_en && bus.full)  bus.overflow <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Scoreboard bench for uart_tx_queue with a behavioural uart_tx busy model.
module tb_uart_tx_queue;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_tx_queue_if #(.DATA_W(8), .FRAME_W(10)) bus ();
    uart_tx_queue #(.DEPTH(8), .DATA_W(8), .FRAME_W(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [9:0] exp_q[$];
    int         frames   = 0;
    int         cnt      = 0;
    int         busy_len = 40;
    bit         stuck    = 1'b0;
    logic [9:0] cur_frame = '0;
    logic       prev_start = 1'b0;

    assign bus.tx_busy = stuck || (cnt != 0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transmitter model and monitor: accepts a frame when start is seen while
    // idle, checks it against the scoreboard, then holds busy for busy_len cycles.
    always @(negedge clk) begin
        if (!reset) begin
            cnt        = 0;
            prev_start = 1'b0;
        end else begin
            if (bus.tx_start && !bus.tx_busy) begin
                frames++;
                chk("start_gap", 32'(prev_start), 32'd0);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL spurious_frame: got %0h expected none", bus.tx_data);
                end else begin
                    chk("frame_data", 32'(bus.tx_data), 32'(exp_q.pop_front()));
                end
                cur_frame = bus.tx_data;
                cnt       = busy_len;
            end else if (cnt != 0) begin
                chk("data_hold", 32'(bus.tx_data), 32'(cur_frame));
                cnt--;
            end
            prev_start = bus.tx_start;
        end
    end

    // Drive one write at the current negedge; returns at the following negedge.
    task automatic wr(input logic [7:0] b, input bit keep);
        bus.wr_en   = 1'b1;
        bus.wr_data = b;
        if (keep) exp_q.push_back({2'b00, b});
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic drain(input int max);
        int i = 0;
        while ((exp_q.size() != 0 || cnt != 0 || bus.tx_start || !bus.empty) && i < max) begin
            @(negedge clk);
            i++;
        end
        if (i >= max) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d queued expected 0", exp_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with a write pending
        reset       = 1'b0;
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h11;
        repeat (3) @(negedge clk);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_start", 32'(bus.tx_start), 32'd0);
        chk("rst_data", 32'(bus.tx_data), 32'd0);
`ifdef UART_TXQ_OVF_EN
        chk("rst_ovf", 32'(bus.overflow), 32'd0);
`endif
        bus.wr_en = 1'b0;
        reset     = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_start", 32'(bus.tx_start), 32'd0);
        chk("idle_empty", 32'(bus.empty), 32'd1);
        chk("idle_frames", 32'(frames), 32'd0);

        // Single byte with a long busy period
        busy_len = 40;
        wr(8'h56, 1'b1);
        chk("wr_empty", 32'(bus.empty), 32'd0);
        chk("wr_start0", 32'(bus.tx_start), 32'd0);
        @(negedge clk);
        chk("pop_start", 32'(bus.tx_start), 32'd1);
        chk("pop_data", 32'(bus.tx_data), 32'h056);
        @(negedge clk);
        chk("start_drop", 32'(bus.tx_start), 32'd0);
        drain(200);
        chk("single_frames", 32'(frames), 32'd1);

        // Burst of four consecutive writes
        busy_len = 6;
        wr(8'h69, 1'b1);
        wr(8'h76, 1'b1);
        wr(8'h65, 1'b1);
        wr(8'h6B, 1'b1);
        drain(300);
        chk("burst_frames", 32'(frames), 32'd5);

        // Fill to DEPTH with busy stuck, then overflow attempt
        stuck = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr(8'h80 + 8'(i), 1'b1);
            chk("fill_full", 32'(bus.full), 32'(i == 7));
        end
        wr(8'hAA, 1'b0);
        chk("ovf_full", 32'(bus.full), 32'd1);
        chk("ovf_count", 32'(dut.u_fifo.count), 32'd8);
`ifdef UART_TXQ_OVF_EN
        chk("ovf_flag", 32'(bus.overflow), 32'd1);
`endif
        stuck = 1'b0;
        @(negedge clk);
        chk("full_release", 32'(bus.full), 32'd0);
        drain(600);
        chk("fill_frames", 32'(frames), 32'd13);
`ifdef UART_TXQ_OVF_EN
        chk("ovf_sticky", 32'(bus.overflow), 32'd1);
`endif

        // Push and pop in the same cycle with three entries queued
        stuck = 1'b1;
        wr(8'h31, 1'b1);
        wr(8'h32, 1'b1);
        wr(8'h33, 1'b1);
        chk("pp_count_pre", 32'(dut.u_fifo.count), 32'd3);
        stuck = 1'b0;
        wr(8'h34, 1'b1);
        chk("pp_count", 32'(dut.u_fifo.count), 32'd3);
        chk("pp_start", 32'(bus.tx_start), 32'd1);
        drain(300);
        chk("pp_frames", 32'(frames), 32'd17);

        // Reset while in WAIT with two bytes queued
        busy_len = 30;
        wr(8'hC1, 1'b1);
        wr(8'hC2, 1'b0);
        wr(8'hC3, 1'b0);
        repeat (3) @(negedge clk);
        chk("wait_count", 32'(dut.u_fifo.count), 32'd2);
        reset = 1'b0;
        #1;
        chk("mid_rst_start", 32'(bus.tx_start), 32'd0);
        chk("mid_rst_empty", 32'(bus.empty), 32'd1);
        chk("mid_rst_data", 32'(bus.tx_data), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (60) @(negedge clk);
        chk("post_rst_frames", 32'(frames), 32'd18);
        chk("post_rst_sb", 32'(exp_q.size()), 32'd0);
        chk("post_rst_empty", 32'(bus.empty), 32'd1);
        chk("post_rst_start", 32'(bus.tx_start), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_queue.md
# uart_tx_queue

Byte queue and start-handshake sequencer sitting directly upstream of `uart_tx`. Accepts bytes from a host-side write port into a synchronous FIFO and presents them one at a time to the transmitter via its `in`/`start`/`busy` handshake, so software never polls `busy`. One clock domain, shared with the transmitter.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `DATA_W`, 8: host byte width; ≤10.
- `FRAME_W`, 10: transmitter data-input width; `tx_data` = zero-extended byte.

- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `wr_en`  in  1  push `wr_data` this cycle.
- `wr_data`  in  DATA_W  byte to queue.
- `full`  out  1  FIFO holds DEPTH entries; write ignored.
- `empty`  out  1  FIFO holds 0 entries.
- `tx_data`  out  FRAME_W  to `uart_tx.in`.
- `tx_start`  out  1  to `uart_tx.start`.
- `tx_busy`  in  1  from `uart_tx.busy`.

## Operation
- Reset (async assert, sync release): FIFO pointers and count 0, `empty`=1, `full`=0, `tx_start`=0, `tx_data`=0, state IDLE.
- Write: accepted iff `wr_en` && !`full`; write while full dropped silently, no state change.
- FSM:
  - IDLE: `tx_start`=0. If !`empty` && !`tx_busy`: pop head into `tx_data` register, → START.
  - START: `tx_start`=1, `tx_data` held. On `tx_busy`=1 → WAIT.
  - WAIT: `tx_start`=0, `tx_data` held. On `tx_busy`=0 → IDLE.
- `tx_data` changes only on a pop; stable across START and WAIT.
- Push and pop in same cycle: count unchanged, both succeed (push allowed only if !`full` before the edge).
- Pointers wrap modulo DEPTH; count width clog2(DEPTH)+1.
- `full`/`empty` registered, derived from count; reflect state after the edge.
- Reset mid-frame: queue contents lost, `tx_start` drops immediately; transmitter reset by same net.

## Timing
- Write sampled at edge k with queue empty and FSM IDLE: `empty`=0 after edge k; pop at edge k+1; `tx_start`=1 and `tx_data` valid after edge k+1.
- `tx_start` stays high until the edge after `tx_busy` is first sampled 1 (≥1 cycle).
- Back-to-back bytes: next pop no earlier than the edge after `tx_busy` sampled 0 in WAIT; min 1 IDLE cycle between frames.
- `full` deasserts the edge after the pop that frees an entry.
- No combinational path from `tx_busy` or `wr_en` to any output.

## Configuration
- `UART_TXQ_OVF_EN` defined: adds output `overflow` (1 bit), set sticky on any write attempt while `full`, cleared only by reset; reset value 0.
- Not defined: port absent, dropped writes are unreported; all other behaviour identical.

## Structure
- Shared package `uart_pkg`: FSM state enum (IDLE, START, WAIT), `FRAME_W` constant, frame zero-extension helper.
- Sub-module `uart_txq_fifo`: parameterised synchronous FIFO (storage, pointers, count, `full`/`empty`); `uart_tx_queue` holds FSM and `tx_data` register.

## Test plan
- Reset held low with `wr_en`=1 → `empty`=1, `full`=0, `tx_start`=0, `tx_data`=0; release, no writes → stays IDLE.
- Single write 8'h56, behavioural transmitter busy 40 cycles → `tx_start`=1 two edges after write, `tx_data`=10'h056, `tx_start` low after busy seen, exactly one frame.
- Burst 8'h69, 8'h76, 8'h65, 8'h6B in consecutive cycles → frames delivered in order, `tx_data` stable through each busy period, ≥1 idle cycle between starts.
- Fill DEPTH=8 with busy stuck high, then 9th write 8'hAA → `full`=1, 8'hAA never transmitted; with `UART_TXQ_OVF_EN`, `overflow`=1 and sticky.
- Simultaneous push and pop with count 3 → count remains 3, order preserved across pointer wrap after >8 total bytes.
- Assert reset during WAIT with 2 bytes queued → `tx_start`=0 and `empty`=1 immediately; after release no stale frame sent.
